// File: rtl/obstacle_game_controller.sv
// Game-flow sequencer for the hard-mode obstacle generator.
// Runs IDLE -> COUNTDOWN -> RUN -> CRASH -> IDLE, drives the generator's
// enable and step period, detects player/obstacle collisions and keeps
// the current and best scores for the display overlay.
module obstacle_game_controller #(
  parameter logic [31:0] SECOND_TICKS = 32'd25_000_000,
  parameter logic [31:0] SCORE_TICKS  = 32'd2_500_000,
  parameter logic [31:0] LEVEL_TICKS  = 32'd250_000_000,
  parameter logic [31:0] SPEED_START  = 32'd250_000,
  parameter logic [31:0] SPEED_STEP   = 32'd25_000,
  parameter logic [31:0] SPEED_MIN    = 32'd100_000,
  parameter logic [31:0] CRASH_TICKS  = 32'd50_000_000
) (
  input  logic        clock_25mhz,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        is_obstacle_hitbox,
  input  logic        is_player_pixel,
  output logic        game_active,
  output logic [31:0] speed,
  output logic [1:0]  state,
  output logic [1:0]  countdown_digit,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        crash_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_CRASH     = 2'd3
  } state_t;

  // Motion is frozen by presenting the largest possible step period.
  localparam logic [31:0] SPEED_FROZEN = 32'hFFFF_FFFF;

  state_t      state_r;
  logic        start_q;
  logic [31:0] speed_reg;
  logic [31:0] second_cnt;
  logic [31:0] score_cnt;
  logic [31:0] level_cnt;
  logic [31:0] crash_cnt;
  logic        start_edge;
  logic        collision;

  // Score counter saturates instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    sat_inc = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // One difficulty step: shorten the period, clamped at the floor.
  // Compared at 33 bits so MIN+STEP cannot overflow and speed never wraps.
  function automatic logic [31:0] next_speed(input logic [31:0] cur);
    logic [32:0] limit;
    limit = {1'b0, SPEED_MIN} + {1'b0, SPEED_STEP};
    next_speed = ({1'b0, cur} >= limit) ? (cur - SPEED_STEP) : SPEED_MIN;
  endfunction

  assign start_edge = start_btn & ~start_q;
  assign collision  = is_obstacle_hitbox & is_player_pixel;
  assign state      = state_r;

  // Game-flow state machine with all outputs registered.
  always_ff @(posedge clock_25mhz or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      start_q         <= 1'b0;
      game_active     <= 1'b0;
      speed           <= SPEED_START;
      speed_reg       <= SPEED_START;
      countdown_digit <= 2'd0;
      score           <= 16'd0;
      high_score      <= 16'd0;
      crash_pulse     <= 1'b0;
      second_cnt      <= 32'd0;
      score_cnt       <= 32'd0;
      level_cnt       <= 32'd0;
      crash_cnt       <= 32'd0;
    end else begin
      start_q     <= start_btn;
      crash_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          game_active <= 1'b0;
          if (start_edge) begin
            state_r         <= ST_COUNTDOWN;
            score           <= 16'd0;
            speed_reg       <= SPEED_START;
            speed           <= SPEED_START;
            score_cnt       <= 32'd0;
            level_cnt       <= 32'd0;
            countdown_digit <= 2'd3;
            second_cnt      <= 32'd0;
          end
        end
        ST_COUNTDOWN: begin
          game_active <= 1'b0;
          if (second_cnt == SECOND_TICKS - 32'd1) begin
            second_cnt <= 32'd0;
            if (countdown_digit == 2'd1) begin
              state_r         <= ST_RUN;
              countdown_digit <= 2'd0;
              game_active     <= 1'b1;
            end else begin
              countdown_digit <= countdown_digit - 2'd1;
            end
          end else begin
            second_cnt <= second_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          game_active <= 1'b1;
          if (collision) begin
            // Score and level ticks landing on this cycle are dropped.
            state_r     <= ST_CRASH;
            crash_pulse <= 1'b1;
            speed       <= SPEED_FROZEN;
            crash_cnt   <= 32'd0;
            high_score  <= (score > high_score) ? score : high_score;
          end else begin
            if (score_cnt == SCORE_TICKS - 32'd1) begin
              score_cnt <= 32'd0;
              score     <= sat_inc(score);
            end else begin
              score_cnt <= score_cnt + 32'd1;
            end
            if (level_cnt == LEVEL_TICKS - 32'd1) begin
              level_cnt <= 32'd0;
              speed_reg <= next_speed(speed_reg);
              speed     <= next_speed(speed_reg);
            end else begin
              level_cnt <= level_cnt + 32'd1;
            end
          end
        end
        ST_CRASH: begin
          game_active <= 1'b1;
          if (crash_cnt == CRASH_TICKS - 32'd1) begin
            state_r     <= ST_IDLE;
            game_active <= 1'b0;
            speed       <= speed_reg;
            crash_cnt   <= 32'd0;
          end else begin
            crash_cnt <= crash_cnt + 32'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_game_controller.sv
// Self-checking bench for obstacle_game_controller with a scoreboard queue:
// each driven cycle pushes the outputs expected after the next clock edge,
// and a monitor pops and compares them just after that edge.
module tb_obstacle_game_controller;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CD   = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_CR   = 2'd3;

  logic        clock_25mhz = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        is_obstacle_hitbox;
  logic        is_player_pixel;
  logic        game_active;
  logic [31:0] speed;
  logic [1:0]  state;
  logic [1:0]  countdown_digit;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        crash_pulse;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  dig;
    logic        ga;
    logic [31:0] spd;
    logic [15:0] sc;
    logic [15:0] hs;
    logic        cp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] hs_exp = 16'd0;

  obstacle_game_controller #(
    .SECOND_TICKS(32'd4),
    .SCORE_TICKS (32'd3),
    .LEVEL_TICKS (32'd10),
    .SPEED_START (32'd20),
    .SPEED_STEP  (32'd6),
    .SPEED_MIN   (32'd5),
    .CRASH_TICKS (32'd8)
  ) dut (
    .clock_25mhz       (clock_25mhz),
    .reset             (reset),
    .start_btn         (start_btn),
    .is_obstacle_hitbox(is_obstacle_hitbox),
    .is_player_pixel   (is_player_pixel),
    .game_active       (game_active),
    .speed             (speed),
    .state             (state),
    .countdown_digit   (countdown_digit),
    .score             (score),
    .high_score        (high_score),
    .crash_pulse       (crash_pulse)
  );

  always #5 clock_25mhz = ~clock_25mhz;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] st, input logic [1:0] dig, input logic ga,
                              input logic [31:0] spd, input logic [15:0] sc,
                              input logic [15:0] hs, input logic cp);
    exp_t e;
    e.st = st; e.dig = dig; e.ga = ga; e.spd = spd; e.sc = sc; e.hs = hs; e.cp = cp;
    return e;
  endfunction

  // Step period shown after r RUN cycles: 20 -> 14 -> 8 -> 5 every 10 cycles.
  function automatic logic [31:0] speed_of(input int r);
    case (r / 10)
      0:       return 32'd20;
      1:       return 32'd14;
      2:       return 32'd8;
      default: return 32'd5;
    endcase
  endfunction

  function automatic logic [15:0] score_of(input int r);
    return 16'(r / 3);
  endfunction

  // Compare everything the edge just produced against the scoreboard head.
  always @(posedge clock_25mhz) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("state",       {30'd0, state},           {30'd0, e.st});
      check_val("digit",       {30'd0, countdown_digit}, {30'd0, e.dig});
      check_val("game_active", {31'd0, game_active},     {31'd0, e.ga});
      check_val("speed",       speed,                    e.spd);
      check_val("score",       {16'd0, score},           {16'd0, e.sc});
      check_val("high_score",  {16'd0, high_score},      {16'd0, e.hs});
      check_val("crash_pulse", {31'd0, crash_pulse},     {31'd0, e.cp});
    end
  end

  task automatic step(input logic sb, input logic hit, input logic pl, input exp_t e);
    @(negedge clock_25mhz);
    start_btn          = sb;
    is_obstacle_hitbox = hit;
    is_player_pixel    = pl;
    sb_q.push_back(e);
  endtask

  // Press start from IDLE, walk the 3-2-1 countdown into RUN cycle 0.
  task automatic start_game(input bit toggle);
    step(1'b1, 1'b0, 1'b0, mk(S_CD, 2'd3, 1'b0, 32'd20, 16'd0, hs_exp, 1'b0));
    for (int k = 1; k < 12; k++)
      step(toggle ? logic'(k % 2 == 0) : 1'b0, 1'b0, 1'b0,
           mk(S_CD, 2'(3 - k / 4), 1'b0, 32'd20, 16'd0, hs_exp, 1'b0));
    step(1'b0, 1'b0, 1'b0, mk(S_RUN, 2'd0, 1'b1, 32'd20, 16'd0, hs_exp, 1'b0));
  endtask

  // Advance RUN to cycle n; optionally assert only one collision flag at a time.
  task automatic run_to(input int n, input bit noise);
    logic h, p;
    for (int r = 1; r <= n; r++) begin
      h = 1'b0; p = 1'b0;
      if (noise) begin
        if (r % 5 == 0) h = 1'b1;
        else if (r % 7 == 0) p = 1'b1;
      end
      step(1'b0, h, p, mk(S_RUN, 2'd0, 1'b1, speed_of(r), score_of(r), hs_exp, 1'b0));
    end
  endtask

  // Collide during RUN cycle r, then follow CRASH back to IDLE.
  task automatic crash_at(input int r, input bit toggle);
    if (score_of(r) > hs_exp) hs_exp = score_of(r);
    step(1'b0, 1'b1, 1'b1, mk(S_CR, 2'd0, 1'b1, 32'hFFFF_FFFF, score_of(r), hs_exp, 1'b1));
    for (int j = 1; j < 8; j++)
      step((toggle && j < 7) ? logic'(j % 2) : 1'b0, logic'(j % 2), logic'(j % 2),
           mk(S_CR, 2'd0, 1'b1, 32'hFFFF_FFFF, score_of(r), hs_exp, 1'b0));
    step(1'b0, 1'b0, 1'b0, mk(S_IDLE, 2'd0, 1'b0, speed_of(r), score_of(r), hs_exp, 1'b0));
    step(1'b0, 1'b1, 1'b1, mk(S_IDLE, 2'd0, 1'b0, speed_of(r), score_of(r), hs_exp, 1'b0));
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, {30'd0, state},           32'd0);
    check_val({tag, "_ga"},    {31'd0, game_active},     32'd0);
    check_val({tag, "_speed"}, speed,                    32'd20);
    check_val({tag, "_digit"}, {30'd0, countdown_digit}, 32'd0);
    check_val({tag, "_score"}, {16'd0, score},           32'd0);
    check_val({tag, "_hs"},    {16'd0, high_score},      32'd0);
    check_val({tag, "_pulse"}, {31'd0, crash_pulse},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    start_btn          = 1'b0;
    is_obstacle_hitbox = 1'b0;
    is_player_pixel    = 1'b0;
    #1;
    check_reset_values("rst0");
    @(negedge clock_25mhz);
    @(negedge clock_25mhz);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, mk(S_IDLE, 2'd0, 1'b0, 32'd20, 16'd0, 16'd0, 1'b0));
    step(1'b0, 1'b1, 1'b1, mk(S_IDLE, 2'd0, 1'b0, 32'd20, 16'd0, 16'd0, 1'b0));

    // Game 1: collision at RUN cycle 7 -> score 2, high score 2
    start_game(1'b0);
    run_to(7, 1'b1);
    crash_at(7, 1'b0);

    // Game 2: start pressed during countdown and crash; score 1 keeps high score 2
    start_game(1'b1);
    run_to(4, 1'b0);
    crash_at(4, 1'b1);

    // Game 3: 45+ cycles of difficulty ramp with single-flag noise; crash on a score tick
    start_game(1'b0);
    run_to(47, 1'b1);
    crash_at(47, 1'b0);

    // Game 4: crash on a cycle that is both a score and a level tick
    start_game(1'b0);
    run_to(29, 1'b0);
    crash_at(29, 1'b0);

    // Game 5: asynchronous reset mid-RUN with start held through release
    start_game(1'b0);
    run_to(5, 1'b0);
    @(negedge clock_25mhz);
    reset     = 1'b1;
    start_btn = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(negedge clock_25mhz);
    check_reset_values("rst_hold");
    hs_exp = 16'd0;
    reset  = 1'b0;
    sb_q.push_back(mk(S_CD, 2'd3, 1'b0, 32'd20, 16'd0, 16'd0, 1'b0));
    for (int k = 1; k < 6; k++)
      step(1'b1, 1'b0, 1'b0, mk(S_CD, 2'(3 - k / 4), 1'b0, 32'd20, 16'd0, 16'd0, 1'b0));

    @(posedge clock_25mhz);
    #3;
    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
